// File: rtl/counter_value_source.sv
// counter_value_source: debounced pushbutton/auto-run 8-bit wrap-around counter for the display stage.
module counter_value_source #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clr,
  input  logic       btn_mode,
  input  logic       sw_dir,
  output logic [7:0] value,
  output logic       running,
  output logic       wrap
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TICK_CYCLES);
  typedef enum logic {MANUAL = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_next;
  logic [4:0] s1, s2;
  logic [3:0] deb, deb_d, pulse;
  logic [CW-1:0] cnt [4];
  logic [TW-1:0] presc;
  logic tick, up, dn;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      deb_d <= '0;
    end else begin
      s1 <= {sw_dir, btn_mode, btn_clr, btn_down, btn_up};
      s2 <= s1;
      deb_d <= deb;
    end
  // bits 0..3 = up, down, clr, mode; sw_dir (bit 4) is only synchronised
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      deb <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (s2[k] == deb[k]) cnt[k] <= '0;
        else if (cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[k] <= '0;
          deb[k] <= s2[k];
        end else cnt[k] <= cnt[k] + 1'b1;
    end
  assign pulse = deb & ~deb_d;
  assign tick = (state == RUN) && (presc == TW'(TICK_CYCLES - 1));
  always_comb begin
    state_next = pulse[3] ? ((state == RUN) ? MANUAL : RUN) : state;
    up = (state == RUN) ? (tick & s2[4]) : (pulse[0] & ~pulse[1]);
    dn = (state == RUN) ? (tick & ~s2[4]) : (pulse[1] & ~pulse[0]);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= MANUAL;
    else state <= state_next;
  assign running = (state == RUN);
  always_ff @(posedge clk or negedge rst)
    if (!rst) presc <= '0;
    else if (pulse[2] || (pulse[3] && state == MANUAL)) presc <= '0;
    else if (state == RUN && !pulse[3]) presc <= tick ? '0 : presc + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      value <= '0;
      wrap <= 1'b0;
    end else if (pulse[2]) begin
      value <= '0;
      wrap <= 1'b0;
    end else if (up) begin
      value <= value + 1'b1;
      wrap <= (value == 8'hFF);
    end else if (dn) begin
      value <= value - 1'b1;
      wrap <= (value == 8'h00);
    end else wrap <= 1'b0;
endmodule

// File: tb/tb_counter_value_source.sv
// tb_counter_value_source: directed plus random stimulus against a behavioural reference model.
module tb_counter_value_source;
  localparam int D = 4;
  localparam int T = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] btns = 4'b0;
  logic sw_dir = 1'b0;
  logic [7:0] value;
  logic running, wrap;
  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] q [$];
  logic [3:0] m_deb, m_rose;
  int m_len [4];
  bit m_run, m_wrap;
  int m_ph, m_val;

  counter_value_source #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .btn_up(btns[0]), .btn_down(btns[1]), .btn_clr(btns[2]),
    .btn_mode(btns[3]), .sw_dir(sw_dir), .value(value), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    q = '{5'b0, 5'b0};
    m_deb = '0;
    m_rose = '0;
    for (int k = 0; k < 4; k++) m_len[k] = 0;
    m_run = 0;
    m_ph = 0;
    m_val = 0;
    m_wrap = 0;
  endfunction

  // One clock edge of behaviour: raw inputs reach the debouncer two edges late,
  // a debounced rise acts one edge after it happens.
  function automatic void m_step();
    logic [4:0] cur;
    logic [3:0] p;
    bit tk, stepping, go_up;
    cur = q.pop_front();
    q.push_back({sw_dir, btns});
    p = m_rose;
    tk = m_run && (m_ph == T - 1);
    m_wrap = 0;
    stepping = m_run ? tk : (p[0] != p[1]);
    go_up = m_run ? cur[4] : p[0];
    if (p[2]) m_val = 0;
    else if (stepping) begin
      m_wrap = go_up ? (m_val == 255) : (m_val == 0);
      m_val = go_up ? (m_val + 1) % 256 : (m_val + 255) % 256;
    end
    if (p[2] || (p[3] && !m_run)) m_ph = 0;
    else if (m_run && !p[3]) m_ph = (m_ph + 1) % T;
    if (p[3]) m_run = !m_run;
    for (int k = 0; k < 4; k++) begin
      m_rose[k] = 1'b0;
      if (cur[k] != m_deb[k]) begin
        m_len[k]++;
        if (m_len[k] == D) begin
          m_deb[k] = cur[k];
          m_len[k] = 0;
          m_rose[k] = cur[k];
        end
      end else m_len[k] = 0;
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!rst) m_reset();
      else m_step();
      #1;
      chk("value", value, 8'(m_val));
      chk("running", {7'd0, running}, {7'd0, m_run});
      chk("wrap", {7'd0, wrap}, {7'd0, m_wrap});
    end
  endtask

  task automatic press(input int b);
    btns[b] = 1'b1;
    cyc(D + 3);
    btns[b] = 1'b0;
    cyc(D + 3);
  endtask

  initial begin
    int v0;
    int i;
    m_reset();
    btns[0] = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(6);
    chk("rst_hold_value", value, 8'd0);
    cyc(1);
    chk("rst_first_inc", value, 8'd1);
    chk("rst_running", {7'd0, running}, 8'd0);
    chk("rst_wrap", {7'd0, wrap}, 8'd0);
    btns = 4'b0;
    cyc(10);
    press(2);
    chk("clear", value, 8'd0);
    btns[0] = 1'b1;
    cyc(3);
    btns[0] = 1'b0;
    cyc(2);
    btns[0] = 1'b1;
    cyc(D + 2);
    chk("glitch_ignored", value, 8'd0);
    cyc(1);
    chk("bounce_one_step", value, 8'd1);
    btns[0] = 1'b0;
    cyc(D + 3);
    repeat (3) press(0);
    chk("three_presses", value, 8'd4);
    press(2);
    btns[1] = 1'b1;
    cyc(D + 3);
    chk("down_wrap_value", value, 8'd255);
    chk("down_wrap_pulse", {7'd0, wrap}, 8'd1);
    cyc(1);
    chk("down_wrap_once", {7'd0, wrap}, 8'd0);
    btns[1] = 1'b0;
    cyc(D + 3);
    btns[0] = 1'b1;
    cyc(D + 3);
    chk("up_wrap_value", value, 8'd0);
    chk("up_wrap_pulse", {7'd0, wrap}, 8'd1);
    btns[0] = 1'b0;
    cyc(D + 3);
    sw_dir = 1'b1;
    press(3);
    chk("run_entered", {7'd0, running}, 8'd1);
    cyc(40);
    sw_dir = 1'b0;
    cyc(40);
    press(3);
    chk("run_left", {7'd0, running}, 8'd0);
    v0 = m_val;
    cyc(20);
    chk("manual_frozen", value, 8'(v0));
    btns = 4'b0011;
    cyc(D + 3);
    chk("up_down_cancel", value, 8'(v0));
    btns = 4'b0;
    cyc(D + 3);
    press(2);
    for (i = 0; i < 200; i++) press(0);
    chk("reach_200", value, 8'd200);
    btns = 4'b0101;
    cyc(D + 3);
    chk("clr_over_up_value", value, 8'd0);
    chk("clr_over_up_wrap", {7'd0, wrap}, 8'd0);
    btns = 4'b0;
    cyc(D + 3);
    press(2);
    press(1);
    press(1);
    sw_dir = 1'b1;
    press(3);
    for (i = 0; i < 64 && !(m_val == 255 && m_ph == ((T - 1 - (D + 2)) % T + T) % T); i++) cyc(1);
    chk("align_budget", 8'(i < 64), 8'd1);
    btns[3] = 1'b1;
    cyc(D + 2);
    chk("pre_tick_value", value, 8'd255);
    chk("pre_tick_running", {7'd0, running}, 8'd1);
    cyc(1);
    chk("mode_tick_value", value, 8'd0);
    chk("mode_tick_wrap", {7'd0, wrap}, 8'd1);
    chk("mode_tick_running", {7'd0, running}, 8'd0);
    btns[3] = 1'b0;
    cyc(D + 3);
    press(0);
    chk("manual_after_run", value, 8'd1);
    for (i = 0; i < 150; i++) begin
      btns = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) btns[2] = 1'b0;
      if ($urandom_range(0, 4) == 0) sw_dir = ~sw_dir;
      cyc($urandom_range(1, 2 * D + 4));
    end
    btns = 4'b0;
    cyc(2 * D + 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/counter_value_source.md
Name: counter_value_source

Overview:
- Produces the 8-bit `value` consumed directly by the 3-digit seven-segment display stage.
- Takes raw board pushbuttons and slide switches, then synchronises, debounces and edge-detects them.
- Drives an 8-bit wrap-around counter in two modes: MANUAL (button-stepped) and RUN (auto-stepped at a prescaled tick rate).

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles a synchronised button must hold a new level before its debounced level changes (10 ms at 100 MHz); minimum 2.
- TICK_CYCLES, 50000000, clk cycles per auto-step in RUN (0.5 s at 100 MHz); minimum 2.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-low reset.
- btn_up  input  1  raw pushbutton, asynchronous, active-high: step +1 in MANUAL.
- btn_down  input  1  raw pushbutton, asynchronous, active-high: step -1 in MANUAL.
- btn_clr  input  1  raw pushbutton, asynchronous, active-high: clear value to 0 in any mode.
- btn_mode  input  1  raw pushbutton, asynchronous, active-high: toggle MANUAL/RUN.
- sw_dir  input  1  raw slide switch, asynchronous: RUN direction, 1 = up, 0 = down. Synchronised only, not debounced.
- value  output  8  current count, unsigned 0..255, registered.
- running  output  1  1 while FSM is in RUN, registered.
- wrap  output  1  one-cycle pulse on the cycle value wraps 255->0 or 0->255, registered.

Behaviour:
- Reset (rst=0, async):
  - value=0, running=0, wrap=0, FSM=MANUAL.
  - Synchroniser flops, debounced levels, debounce counters and prescaler all cleared to 0.
  - Reset mid-press: after release of rst, a still-held button must debounce afresh before it has any effect.
- Synchronisation: each raw input passes through 2 flops.
- Debounce (per button, independent):
  - A counter increments while the synchronised level differs from the debounced level, and clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- Edge detect: a press pulse is asserted for exactly 1 cycle, the cycle after the debounced level rises 0->1. Release generates nothing.
- Latency: value/running update on the clock edge after the press pulse cycle.
  - Total from the first clk edge sampling the raw high level to value change = DEBOUNCE_CYCLES+3 cycles.
- FSM states: MANUAL, RUN.
  - MANUAL --mode pulse--> RUN: prescaler cleared to 0 on entry.
  - RUN --mode pulse--> MANUAL: prescaler frozen.
- Prescaler (RUN only):
  - Counts 0..TICK_CYCLES-1 and wraps.
  - A tick occurs on the cycle it equals TICK_CYCLES-1. First tick is TICK_CYCLES cycles after entering RUN.
- Step sources:
  - MANUAL: up pulse -> +1; down pulse -> -1. Up and down pulses in the same cycle cancel (no change, wrap=0).
  - RUN: tick -> +1 if synchronised sw_dir=1, else -1. Up/down pulses are ignored.
- Arithmetic: modulo 256.
  - 255+1 -> 0 with wrap=1; 0-1 -> 255 with wrap=1.
  - All other steps give wrap=0.
- Clear has priority over every step in the same cycle:
  - value <- 0, wrap=0.
  - Mode unchanged; prescaler restarts from 0 if in RUN.
- Simultaneous clr and mode pulses: clear is applied and mode toggles.
- Simultaneous mode and tick (RUN): the tick step is applied, then mode -> MANUAL.
- running mirrors the FSM state, registered, same cycle as the state change.
- No combinational path from any input to any output.

Test Plan:
- Reset with DEBOUNCE_CYCLES=4 and TICK_CYCLES=8; hold rst=0 with btn_up=1, release rst and keep btn_up=1 -> value=0 during reset; value becomes 1 exactly 7 cycles after the first post-reset edge; running=0, wrap=0.
- MANUAL bounce: btn_up pulses high for 3 cycles, low for 2, then held high -> exactly one increment, 0->1, with no step from the 3-cycle glitch. Release, then 3 clean presses -> value=4.
- Wrap both ways: from 0, press btn_down -> value=255 with wrap=1 for one cycle; press btn_up -> value=0 with wrap=1 for one cycle.
- RUN: press btn_mode with sw_dir=1 -> running=1; value increments every 8 cycles (0,1,2,...). Flip sw_dir=0 -> decrements begin at the next tick. Pulse btn_mode -> running=0 and counting stops.
- Priority: in MANUAL, debounced up and down pulses in the same cycle -> value unchanged. Clear at value=200 coinciding with an up pulse -> value=0, wrap=0.
- Edge cases in RUN: mode and tick on the same cycle, at value=255 with sw_dir=1 -> value=0, wrap=1, running=0 on the same edge. Then btn_up works in MANUAL -> value=1.
